// File: rtl/plusarg_watchdog_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : plusarg_watchdog_pkg
//  Purpose  : Shared types and constants for the plusarg watchdog.
//             - state_e : watchdog FSM states
//             - c_code_*: report_code encodings (NONE / PASS / TIMEOUT)
//             - c_code_w: width of report_code
//  Revision : 1.0  initial release
// ============================================================================
package plusarg_watchdog_pkg;

  localparam int c_code_w = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  localparam logic [c_code_w-1:0] c_code_none    = 2'd0;
  localparam logic [c_code_w-1:0] c_code_pass    = 2'd1;
  localparam logic [c_code_w-1:0] c_code_timeout = 2'd2;

endpackage
`default_nettype wire

// File: rtl/plusarg_watchdog_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter with synchronous clear and increment enable that
//             sticks at all-ones instead of wrapping.
//  Ports    : clock   - rising-edge clock
//             reset_n - asynchronous active-low reset
//             clr     - synchronous clear (wins over inc)
//             inc     - increment enable
//             count   - current count (registered)
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/plusarg_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : plusarg_watchdog
//  Purpose  : Idle-cycle watchdog driven by a plusarg-supplied limit. Counts
//             cycles since the last progress pulse, latches TIMEOUT when the
//             count reaches the limit or PASS when the harness signals done,
//             reports the verdict once over valid/ready, then halts.
//  Ports    : clock, reset_n      - clock, async active-low reset
//             limit               - idle limit, sampled on arm (0 = disabled)
//             enable              - arm; drop while running to abort
//             progress            - forward-progress pulse
//             done                - harness completion
//             running             - high while in RUN
//             expired             - sticky timeout flag
//             report_valid/ready  - verdict handshake
//             report_code         - NONE / PASS / TIMEOUT
//             report_cycles       - RUN cycles incl. terminating cycle
//  Revision : 1.0  initial release
// ============================================================================
module plusarg_watchdog
  import plusarg_watchdog_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CWIDTH = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    limit,
  input  logic                enable,
  input  logic                progress,
  input  logic                done,
  output logic                running,
  output logic                expired,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [c_code_w-1:0] report_code,
  output logic [CWIDTH-1:0]   report_cycles
);

  state_e              state_q,         state_d;
  logic [WIDTH-1:0]    limit_q,         limit_d;
  logic [WIDTH-1:0]    idle_cnt_q,      idle_cnt_d;
  logic                running_q,       running_d;
  logic                expired_q,       expired_d;
  logic                report_valid_q,  report_valid_d;
  logic [c_code_w-1:0] report_code_q,   report_code_d;
  logic [CWIDTH-1:0]   report_cycles_q, report_cycles_d;

  logic                total_clr;
  logic                total_inc;
  logic [CWIDTH-1:0]   w_total_cnt;
  logic [CWIDTH-1:0]   w_total_next;
  logic                w_timeout_hit;

  sat_counter #(
    .WIDTH (CWIDTH)
  ) u_total_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (total_clr),
    .inc     (total_inc),
    .count   (w_total_cnt)
  );

  // Value total_cnt takes on this edge; report_cycles includes the
  // terminating cycle, so it captures this rather than the current count.
  assign w_total_next = (&w_total_cnt) ? w_total_cnt : (w_total_cnt + CWIDTH'(1));

  // idle_cnt holds the idle cycles already elapsed, so the limit is reached
  // on the cycle where it equals limit-1 and no progress arrives.
  assign w_timeout_hit = (limit_q != '0) && !progress &&
                         (idle_cnt_q == (limit_q - WIDTH'(1)));

  always_comb begin
    state_d         = state_q;
    limit_d         = limit_q;
    idle_cnt_d      = idle_cnt_q;
    running_d       = running_q;
    expired_d       = expired_q;
    report_valid_d  = report_valid_q;
    report_code_d   = report_code_q;
    report_cycles_d = report_cycles_q;
    total_clr       = 1'b0;
    total_inc       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        total_clr  = 1'b1;
        idle_cnt_d = '0;
        if (enable) begin
          limit_d   = limit;
          state_d   = ST_RUN;
          running_d = 1'b1;
        end
      end

      ST_RUN: begin
        total_inc  = 1'b1;
        if (progress) begin
          idle_cnt_d = '0;
        end else if (!(&idle_cnt_q)) begin
          idle_cnt_d = idle_cnt_q + WIDTH'(1);
        end

        if (!enable) begin
          state_d    = ST_IDLE;
          running_d  = 1'b0;
          total_clr  = 1'b1;
          idle_cnt_d = '0;
        end else if (done) begin
          // done outranks a coincident timeout, so expired stays low
          state_d         = ST_REPORT;
          running_d       = 1'b0;
          report_valid_d  = 1'b1;
          report_code_d   = c_code_pass;
          report_cycles_d = w_total_next;
        end else if (w_timeout_hit) begin
          state_d         = ST_REPORT;
          running_d       = 1'b0;
          report_valid_d  = 1'b1;
          report_code_d   = c_code_timeout;
          report_cycles_d = w_total_next;
          expired_d       = 1'b1;
        end
      end

      ST_REPORT: begin
        if (report_ready) begin
          state_d        = ST_HALT;
          report_valid_d = 1'b0;
        end
      end

      ST_HALT: begin
        // terminal until reset; verdict retained
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      limit_q         <= '0;
      idle_cnt_q      <= '0;
      running_q       <= 1'b0;
      expired_q       <= 1'b0;
      report_valid_q  <= 1'b0;
      report_code_q   <= c_code_none;
      report_cycles_q <= '0;
    end else begin
      state_q         <= state_d;
      limit_q         <= limit_d;
      idle_cnt_q      <= idle_cnt_d;
      running_q       <= running_d;
      expired_q       <= expired_d;
      report_valid_q  <= report_valid_d;
      report_code_q   <= report_code_d;
      report_cycles_q <= report_cycles_d;
    end
  end

  assign running       = running_q;
  assign expired       = expired_q;
  assign report_valid  = report_valid_q;
  assign report_code   = report_code_q;
  assign report_cycles = report_cycles_q;

endmodule
`default_nettype wire

// File: doc/plusarg_watchdog.md
# plusarg_watchdog

Simulation-side watchdog that consumes the value produced by a plusarg reader, such as a `+max_idle_cycles=N` timeout, and enforces it against the running design. It counts cycles since the last forward-progress pulse and latches a timeout verdict if the count reaches the plusarg-supplied limit. It also latches a pass verdict if the harness signals completion first. The verdict and total run length are delivered once over a valid/ready report channel to the test harness, after which the block halts until reset.

## Interface
- `WIDTH`, 32: width of `limit` and of the idle counter.
- `CWIDTH`, 64: width of the total-cycle counter and `report_cycles`.
- `clock`  in  1: sole clock; all state changes on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `limit`  in  WIDTH: idle-cycle limit from the plusarg reader. Quasi-static; sampled only on arm. 0 = timeout disabled.
- `enable`  in  1: arms the watchdog; deassertion while running aborts.
- `progress`  in  1: one-cycle forward-progress pulse; clears the idle count.
- `done`  in  1: harness completion indication.
- `running`  out  1: high while in RUN.
- `expired`  out  1: sticky; high once a timeout verdict is latched.
- `report_valid`  out  1: verdict available.
- `report_ready`  in  1: harness accepts verdict.
- `report_code`  out  2: NONE=0, PASS=1, TIMEOUT=2.
- `report_cycles`  out  CWIDTH: RUN cycles elapsed, including the terminating cycle.

## Operation
- States: IDLE, RUN, REPORT, HALT.
- **IDLE**
  - Counters are held at 0.
  - `enable`=1 latches `limit` into `limit_q`; next state is RUN.
- **RUN**
  - Every cycle: `total_cnt` increments, saturating at all-ones.
  - `idle_cnt` clears to 0 when `progress`=1, else increments.
  - Priority order, evaluated each cycle:
    1. `enable`=0: go to IDLE, clear counters, no report.
    2. `done`=1: go to REPORT with code PASS.
    3. `limit_q`≠0 and `progress`=0 and `idle_cnt`==`limit_q`−1: go to REPORT with code TIMEOUT and set `expired`.
    4. Otherwise stay in RUN.
  - `report_cycles` captures `total_cnt`+1 (saturating) on the terminating edge.
- **REPORT**
  - `report_valid`=1; code and cycles are held stable.
  - `report_valid`&`report_ready` → HALT.
- **HALT**
  - `report_valid`=0; code, cycles and `expired` are retained.
  - All inputs are ignored until `reset_n` is asserted.
- `limit_q`=0: the block never times out and exits RUN only via `done` or `enable`=0.
- `done` and timeout in the same cycle: PASS wins and `expired` stays 0.
- `progress` in the would-be timeout cycle prevents the timeout.
- Changes to `limit` after arm have no effect until the next IDLE→RUN transition.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - `running`, `expired`, `report_valid` = 0.
  - `report_code` = NONE, `report_cycles` = 0.
  - Counters and `limit_q` = 0.
- Arm: `enable` is sampled at edge E0; `running`=1 from E0.
- Timeout latency with no progress: `report_valid` and `expired` rise at edge E`limit_q`, with `report_cycles`=`limit_q`.
- `running` falls on the same edge that `report_valid` rises.
- `report_valid` falls on the edge after the handshake completes.
- No combinational paths from inputs to outputs; all outputs are registered.

## Structure
- Package `plusarg_watchdog_pkg` holds:
  - the state enum;
  - the `report_code` constants (NONE, PASS, TIMEOUT);
  - the report-code width.
- Sub-module `sat_counter`: parameterised width, with synchronous clear, increment enable and saturate at all-ones.
  - It is instantiated for `total_cnt`.
  - `idle_cnt` is compared against `limit_q`, so it never wraps.

## Test plan
- **Timeout:** `limit`=4, arm, no progress, `report_ready`=1 → `report_valid` at E4 with code TIMEOUT (2), cycles 4, `expired`=1; HALT on the next cycle.
- **Progress then pass:** `limit`=4, `progress` every 3rd cycle for 20 RUN cycles, then `done` on cycle 21 → code PASS (1), cycles 21, `expired`=0.
- **Disabled limit:** `limit`=0, run 1000 cycles with no progress, then `done` → code PASS, cycles 1001; no timeout at any point.
- **Simultaneous events:**
  - `limit`=3: `done` on cycle 3 together with the timeout → code PASS, `expired`=0.
  - `progress` on cycle 3 → no timeout; the timeout fires at cycle 6 instead.
- **Backpressure and halt:** `report_ready` held low for 10 cycles → valid, code and cycles stable throughout. `ready` pulse → HALT. Afterwards `enable`, `done` and `progress` toggling produce no change.
- **Abort and reset:**
  - `enable` dropped mid-RUN → IDLE with counters cleared.
  - Re-arm with a new `limit`=2 → the timeout honours 2.
  - `reset_n` asserted mid-RUN → all outputs are 0 immediately, before the next clock edge.
